// File: rtl/quant_proc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : quant_proc_arbiter
//  Purpose  : Round-robin arbiter granting NUM_REQ requesters exclusive use of
//             one quantum processor.
//             Optional watchdog abort in RUN is enabled by defining QPA_WATCHDOG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module quant_proc_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DNA_WIDTH      = 32,
    parameter int AGING_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DNA_WIDTH-1:0]   req_dna,
    input  logic [NUM_REQ*AGING_WIDTH-1:0] req_aging,
    input  logic [NUM_REQ*2-1:0]           req_gate,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DNA_WIDTH-1:0]           rsp_dna,
    output logic [15:0]                    rsp_entropy,
    output logic [7:0]                     rsp_mutation,
    output logic                           rsp_timeout,
    output logic                           proc_start,
    output logic [DNA_WIDTH-1:0]           proc_dna_sequence,
    output logic [AGING_WIDTH-1:0]         proc_aging_factor,
    output logic [1:0]                     proc_gate_select,
    input  logic [DNA_WIDTH-1:0]           proc_processed_dna,
    input  logic [15:0]                    proc_entropy_measure,
    input  logic [7:0]                     proc_mutation_count,
    input  logic                           proc_processing_done,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic [15:0]                    grant_count,
    output logic [7:0]                     timeout_count
);

    localparam int c_ID_W = $clog2(NUM_REQ);
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef QPA_WATCHDOG_EN
    localparam bit c_WD_EN = 1'b1;
`else
    localparam bit c_WD_EN = 1'b0;
`endif
    localparam logic [DNA_WIDTH-1:0] c_TO_DNA = DNA_WIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_RUN    = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    typedef logic [c_ID_W:0] idx_ext_t;

    state_t                  state_q, state_d;
    logic [c_ID_W-1:0]       last_winner_q, last_winner_d;
    logic [c_ID_W-1:0]       grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DNA_WIDTH-1:0]    rsp_dna_q, rsp_dna_d;
    logic [15:0]             rsp_entropy_q, rsp_entropy_d;
    logic [7:0]              rsp_mutation_q, rsp_mutation_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    proc_start_q, proc_start_d;
    logic [DNA_WIDTH-1:0]    proc_dna_q, proc_dna_d;
    logic [AGING_WIDTH-1:0]  proc_aging_q, proc_aging_d;
    logic [1:0]              proc_gate_q, proc_gate_d;
    logic                    busy_q, busy_d;
    logic [15:0]             grant_count_q, grant_count_d;
    logic [7:0]              timeout_count_q, timeout_count_d;
    logic [c_WD_W-1:0]       wd_cnt_q, wd_cnt_d;

    logic [DNA_WIDTH-1:0]    w_dna   [NUM_REQ];
    logic [AGING_WIDTH-1:0]  w_aging [NUM_REQ];
    logic [1:0]              w_gate  [NUM_REQ];
    logic                    w_found;
    logic [c_ID_W-1:0]       w_winner;
    idx_ext_t                w_idx;
    logic                    w_wd_expire;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_dna[i]   = req_dna[i*DNA_WIDTH +: DNA_WIDTH];
        assign w_aging[i] = req_aging[i*AGING_WIDTH +: AGING_WIDTH];
        assign w_gate[i]  = req_gate[i*2 +: 2];
    end

    // Round-robin search starting just after the last requester that completed a job.
    always_comb begin
        w_found  = 1'b0;
        w_winner = last_winner_q;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = idx_ext_t'(last_winner_q) + idx_ext_t'(k);
            if (w_idx >= idx_ext_t'(NUM_REQ)) begin
                w_idx = w_idx - idx_ext_t'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[c_ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_ID_W-1:0];
            end
        end
    end

    assign w_wd_expire = c_WD_EN && (wd_cnt_q == c_WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d         = state_q;
        last_winner_d   = last_winner_q;
        grant_id_d      = grant_id_q;
        req_ready_d     = '0;
        rsp_valid_d     = '0;
        rsp_dna_d       = rsp_dna_q;
        rsp_entropy_d   = rsp_entropy_q;
        rsp_mutation_d  = rsp_mutation_q;
        rsp_timeout_d   = rsp_timeout_q;
        proc_start_d    = proc_start_q;
        proc_dna_d      = proc_dna_q;
        proc_aging_d    = proc_aging_q;
        proc_gate_d     = proc_gate_q;
        grant_count_d   = grant_count_q;
        timeout_count_d = timeout_count_q;
        wd_cnt_d        = wd_cnt_q;
        busy_d          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_id_d = w_winner;
                    state_d    = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                wd_cnt_d = '0;
                // A withdrawn request forfeits the grant without moving the round-robin pointer.
                if (req_valid[grant_id_q]) begin
                    req_ready_d[grant_id_q] = 1'b1;
                    proc_dna_d              = w_dna[grant_id_q];
                    proc_aging_d            = w_aging[grant_id_q];
                    proc_gate_d             = w_gate[grant_id_q];
                    proc_start_d            = 1'b1;
                    state_d                 = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (proc_processing_done) begin
                    proc_start_d   = 1'b0;
                    rsp_dna_d      = proc_processed_dna;
                    rsp_entropy_d  = proc_entropy_measure;
                    rsp_mutation_d = proc_mutation_count;
                    rsp_timeout_d  = 1'b0;
                    state_d        = S_RESP;
                end else if (w_wd_expire) begin
                    proc_start_d   = 1'b0;
                    rsp_dna_d      = c_TO_DNA;
                    rsp_entropy_d  = 16'hFFFF;
                    rsp_mutation_d = 8'hFF;
                    rsp_timeout_d  = 1'b1;
                    if (timeout_count_q != 8'hFF) begin
                        timeout_count_d = timeout_count_q + 8'd1;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_d[grant_id_q] = 1'b1;
                last_winner_d           = grant_id_q;
                grant_count_d           = grant_count_q + 16'd1;
                state_d                 = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            last_winner_q   <= c_ID_W'(NUM_REQ - 1);
            grant_id_q      <= '0;
            req_ready_q     <= '0;
            rsp_valid_q     <= '0;
            rsp_dna_q       <= '0;
            rsp_entropy_q   <= '0;
            rsp_mutation_q  <= '0;
            rsp_timeout_q   <= 1'b0;
            proc_start_q    <= 1'b0;
            proc_dna_q      <= '0;
            proc_aging_q    <= '0;
            proc_gate_q     <= '0;
            busy_q          <= 1'b0;
            grant_count_q   <= '0;
            timeout_count_q <= '0;
            wd_cnt_q        <= '0;
        end else begin
            state_q         <= state_d;
            last_winner_q   <= last_winner_d;
            grant_id_q      <= grant_id_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_dna_q       <= rsp_dna_d;
            rsp_entropy_q   <= rsp_entropy_d;
            rsp_mutation_q  <= rsp_mutation_d;
            rsp_timeout_q   <= rsp_timeout_d;
            proc_start_q    <= proc_start_d;
            proc_dna_q      <= proc_dna_d;
            proc_aging_q    <= proc_aging_d;
            proc_gate_q     <= proc_gate_d;
            busy_q          <= busy_d;
            grant_count_q   <= grant_count_d;
            timeout_count_q <= timeout_count_d;
            wd_cnt_q        <= wd_cnt_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_dna           = rsp_dna_q;
    assign rsp_entropy       = rsp_entropy_q;
    assign rsp_mutation      = rsp_mutation_q;
    assign rsp_timeout       = rsp_timeout_q;
    assign proc_start        = proc_start_q;
    assign proc_dna_sequence = proc_dna_q;
    assign proc_aging_factor = proc_aging_q;
    assign proc_gate_select  = proc_gate_q;
    assign busy              = busy_q;
    assign grant_id          = grant_id_q;
    assign grant_count       = grant_count_q;
    assign timeout_count     = timeout_count_q;

endmodule
`default_nettype wire

// File: tb/tb_quant_proc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quant_proc_arbiter
//  Purpose  : Directed, table-driven self-checking bench for quant_proc_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quant_proc_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_dna;
    logic [N*AW-1:0] req_aging;
    logic [N*2-1:0]  req_gate;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_dna;
    logic [15:0]     rsp_entropy;
    logic [7:0]      rsp_mutation;
    logic            rsp_timeout;
    logic            proc_start;
    logic [DW-1:0]   proc_dna_sequence;
    logic [AW-1:0]   proc_aging_factor;
    logic [1:0]      proc_gate_select;
    logic [DW-1:0]   proc_processed_dna;
    logic [15:0]     proc_entropy_measure;
    logic [7:0]      proc_mutation_count;
    logic            proc_processing_done;
    logic            busy;
    logic [1:0]      grant_id;
    logic [15:0]     grant_count;
    logic [7:0]      timeout_count;

    quant_proc_arbiter #(
        .NUM_REQ        (N),
        .DNA_WIDTH      (DW),
        .AGING_WIDTH    (AW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_dna              (req_dna),
        .req_aging            (req_aging),
        .req_gate             (req_gate),
        .req_ready            (req_ready),
        .rsp_valid            (rsp_valid),
        .rsp_dna              (rsp_dna),
        .rsp_entropy          (rsp_entropy),
        .rsp_mutation         (rsp_mutation),
        .rsp_timeout          (rsp_timeout),
        .proc_start           (proc_start),
        .proc_dna_sequence    (proc_dna_sequence),
        .proc_aging_factor    (proc_aging_factor),
        .proc_gate_select     (proc_gate_select),
        .proc_processed_dna   (proc_processed_dna),
        .proc_entropy_measure (proc_entropy_measure),
        .proc_mutation_count  (proc_mutation_count),
        .proc_processing_done (proc_processing_done),
        .busy                 (busy),
        .grant_id             (grant_id),
        .grant_count          (grant_count),
        .timeout_count        (timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        int          id;
        int          delay;
        logic [31:0] dna;
        logic [7:0]  aging;
        logic [1:0]  gate;
        logic [31:0] rdna;
        logic [15:0] ent;
        logic [7:0]  mut;
        logic [15:0] gc;
    } vec_t;

    vec_t vecs [7];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cur_job = 0;
    int   rsp_pulses = 0;

    always @(negedge clk) rsp_pulses <= rsp_pulses + $countones(rsp_valid);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (job %0d): got 0x%0h, expected 0x%0h", name, cur_job, act, exp);
    endfunction

    // One full request/response transaction. delay == 0 means the processor never
    // reports done (watchdog case). Starts and ends with the arbiter in IDLE.
    task automatic run_job(input logic [3:0] mask, input int id, input int delay,
                           input logic [31:0] dna, input logic [7:0] aging, input logic [1:0] gate,
                           input logic [31:0] rdna, input logic [15:0] ent, input logic [7:0] mut,
                           input bit keep, input logic [15:0] gc, input bit to, input logic [7:0] tc);
        logic [3:0] onehot;
        int         cnt;
        int         exp_cnt;
        onehot  = 4'b0001 << id;
        exp_cnt = (delay > 0) ? delay : TO;
        for (int i = 0; i < N; i++) begin
            req_dna[i*DW +: DW]   = (i == id) ? dna : (dna ^ 32'hFFFF0000);
            req_aging[i*AW +: AW] = (i == id) ? aging : ~aging;
            req_gate[i*2 +: 2]    = (i == id) ? gate : ~gate;
        end
        req_valid = mask;
        tick();
        chk("grant_id", 64'(grant_id), 64'(id));
        chk("busy_accept", 64'(busy), 64'd1);
        tick();
        chk("req_ready", 64'(req_ready), 64'(onehot));
        chk("proc_dna_sequence", 64'(proc_dna_sequence), 64'(dna));
        chk("proc_aging_factor", 64'(proc_aging_factor), 64'(aging));
        chk("proc_gate_select", 64'(proc_gate_select), 64'(gate));
        if (!keep) req_valid = req_valid & ~onehot;
        cnt = proc_start ? 1 : 0;
        if (delay > 0) begin
            for (int k = 1; k < delay; k++) begin
                tick();
                if (proc_start) cnt++;
            end
            proc_processed_dna   = rdna;
            proc_entropy_measure = ent;
            proc_mutation_count  = mut;
            proc_processing_done = 1'b1;
            tick();
            proc_processing_done = 1'b0;
        end else begin
            for (int k = 0; k < 200 && proc_start; k++) begin
                tick();
                if (proc_start) cnt++;
            end
        end
        chk("proc_start_cycles", 64'(cnt), 64'(exp_cnt));
        chk("proc_start_cleared", 64'(proc_start), 64'd0);
        chk("req_ready_single_pulse", 64'(req_ready), 64'd0);
        chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
        tick();
        chk("rsp_valid", 64'(rsp_valid), 64'(onehot));
        chk("rsp_dna", 64'(rsp_dna), 64'(rdna));
        chk("rsp_entropy", 64'(rsp_entropy), 64'(ent));
        chk("rsp_mutation", 64'(rsp_mutation), 64'(mut));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(to));
        chk("grant_count", 64'(grant_count), 64'(gc));
        chk("timeout_count", 64'(timeout_count), 64'(tc));
        chk("busy_done", 64'(busy), 64'd0);
        cur_job++;
    endtask

    initial begin
        int p0;
        // mask, winner, done delay, operands, results, expected grant_count
        vecs[0] = '{4'b0100, 2, 5, 32'h1234ABCD, 8'h3C, 2'd2, 32'hCAFE0001, 16'h0A0B, 8'h05, 16'd1};
        vecs[1] = '{4'b0011, 0, 3, 32'h0F0F1111, 8'h11, 2'd1, 32'h11110000, 16'h1234, 8'h01, 16'd2};
        vecs[2] = '{4'b0011, 1, 2, 32'hA5A5A5A5, 8'h80, 2'd3, 32'h5A5A5A5A, 16'hBEEF, 8'h7F, 16'd3};
        vecs[3] = '{4'b1000, 3, 1, 32'h00000001, 8'hFF, 2'd0, 32'hFFFFFFFF, 16'h0001, 8'h80, 16'd4};
        vecs[4] = '{4'b0101, 0, 7, 32'h13579BDF, 8'h42, 2'd2, 32'h2468ACE0, 16'h7777, 8'h33, 16'd5};
        vecs[5] = '{4'b1110, 1, 4, 32'hDEAD0000, 8'h01, 2'd1, 32'h0000BEEF, 16'h8000, 8'h10, 16'd6};
        vecs[6] = '{4'b0001, 0, 2, 32'hCCCC3333, 8'h99, 2'd3, 32'h3333CCCC, 16'h4242, 8'h44, 16'd7};

        rst = 1'b1;
        req_valid = '0; req_dna = '0; req_aging = '0; req_gate = '0;
        proc_processed_dna = '0; proc_entropy_measure = '0; proc_mutation_count = '0;
        proc_processing_done = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_grant_count", 64'(grant_count), 64'd0);
        chk("rst_timeout_count", 64'(timeout_count), 64'd0);
        chk("rst_proc_start", 64'(proc_start), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_dna", 64'(rsp_dna), 64'd0);
        chk("rst_proc_dna", 64'(proc_dna_sequence), 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].mask, vecs[v].id, vecs[v].delay, vecs[v].dna, vecs[v].aging,
                    vecs[v].gate, vecs[v].rdna, vecs[v].ent, vecs[v].mut, 1'b0, vecs[v].gc,
                    1'b0, 8'd0);
        end

        // done while idle must not produce a response
        tick();
        p0 = rsp_pulses;
        proc_processed_dna   = 32'h77777777;
        proc_processing_done = 1'b1;
        repeat (3) tick();
        proc_processing_done = 1'b0;
        chk("idle_done_busy", 64'(busy), 64'd0);
        chk("idle_done_rsp_dna", 64'(rsp_dna), 64'h3333CCCC);
        chk("idle_done_no_rsp", 64'(rsp_pulses), 64'(p0));

        // withdrawal: requester 1 pulses valid for one cycle only
        req_valid = 4'b0010;
        tick();
        chk("wd_grant_id", 64'(grant_id), 64'd1);
        req_valid = '0;
        tick();
        chk("wd_req_ready", 64'(req_ready), 64'd0);
        chk("wd_proc_start", 64'(proc_start), 64'd0);
        chk("wd_busy", 64'(busy), 64'd0);
        tick();
        chk("wd_req_ready_late", 64'(req_ready), 64'd0);
        run_job(4'b0011, 1, 2, 32'h0BADF00D, 8'h07, 2'd0, 32'h00C0FFEE, 16'h0102, 8'h03,
                1'b0, 16'd8, 1'b0, 8'd0);

        // reset while the processor is running
        req_valid = 4'b1000;
        tick();
        tick();
        req_valid = '0;
        repeat (2) tick();
        chk("pre_rst_proc_start", 64'(proc_start), 64'd1);
        p0  = rsp_pulses;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_proc_start", 64'(proc_start), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_grant_count", 64'(grant_count), 64'd0);
        repeat (3) tick();
        chk("mid_rst_no_rsp", 64'(rsp_pulses), 64'(p0));

        // all four requesters held high: strict rotation starting at 0
        p0 = rsp_pulses;
        for (int j = 0; j < 5; j++) begin
            run_job(4'b1111, j % 4, 2, 32'h10000000 * (j + 1), 8'(j + 1), 2'(j),
                    32'hA0000000 | 32'(j), 16'(j), 8'(j), 1'b1, 16'(j + 1), 1'b0, 8'd0);
        end
        req_valid = '0;
        tick();
        chk("rr_rsp_pulses", 64'(rsp_pulses - p0), 64'd5);

`ifdef QPA_WATCHDOG_EN
        run_job(4'b0010, 1, 0, 32'h55550001, 8'h21, 2'd1, 32'hDEADBEEF, 16'hFFFF, 8'hFF,
                1'b0, 16'd6, 1'b1, 8'd1);
        run_job(4'b0100, 2, TO, 32'h55550002, 8'h22, 2'd2, 32'h600DF00D, 16'h1357, 8'h09,
                1'b0, 16'd7, 1'b0, 8'd1);
`else
        run_job(4'b0010, 1, 40, 32'h55550001, 8'h21, 2'd1, 32'h600DF00D, 16'h1357, 8'h09,
                1'b0, 16'd6, 1'b0, 8'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quant_proc_arbiter.md
QUANT_PROC_ARBITER -- requirements
Module: quant_proc_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one quantum processor.
REQ-002 SHALL have parameter DNA_WIDTH, default 32: DNA word width.
REQ-003 SHALL have parameter AGING_WIDTH, default 8: aging factor width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit in RUN.
REQ-005 SHALL use one clock and a synchronous, active-high reset, as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
REQ-006 SHALL have these requester-side ports:
- req_valid  in  NUM_REQ  per-requester request.
- req_dna  in  NUM_REQ*DNA_WIDTH  flattened sequences; requester i at [i*DNA_WIDTH +: DNA_WIDTH].
- req_aging  in  NUM_REQ*AGING_WIDTH  flattened aging factors.
- req_gate  in  NUM_REQ*2  flattened gate selects.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot response pulse.
- rsp_dna  out  DNA_WIDTH  result sequence.
- rsp_entropy  out  16  result entropy.
- rsp_mutation  out  8  result mutation count.
- rsp_timeout  out  1  result is a watchdog abort.
REQ-007 SHALL have these processor-side ports:
- proc_start  out  1  level start, held high until done.
- proc_dna_sequence  out  DNA_WIDTH  operand.
- proc_aging_factor  out  AGING_WIDTH  operand.
- proc_gate_select  out  2  operand.
- proc_processed_dna  in  DNA_WIDTH  result.
- proc_entropy_measure  in  16  result.
- proc_mutation_count  in  8  result.
- proc_processing_done  in  1  completion.
REQ-008 SHALL have these status ports:
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- grant_count  out  16  completed jobs.
- timeout_count  out  8  watchdog aborts.

Function
REQ-009 SHALL implement FSM IDLE -> ACCEPT -> RUN -> RESP -> IDLE; all outputs registered.
REQ-010 IDLE: if any req_valid, SHALL select the winner round-robin, searching from (last_winner+1) mod NUM_REQ, then latch grant_id and go to ACCEPT; else stay in IDLE.
REQ-011 ACCEPT: if req_valid[grant_id] is still 1, SHALL pulse req_ready[grant_id] for exactly this cycle, capture req_dna/aging/gate[grant_id] into the proc_* operand registers, and go to RUN.
REQ-012 ACCEPT: if req_valid[grant_id] has dropped, SHALL assert no req_ready, leave last_winner unchanged, and return to IDLE.
REQ-013 Requesters SHALL hold req_valid and operands stable until req_ready is seen.
REQ-014 RUN: SHALL hold proc_start=1 and operands stable until proc_processing_done=1 is sampled, then clear proc_start, capture the proc results into rsp_*, clear rsp_timeout, and go to RESP.
REQ-015 RESP: SHALL pulse rsp_valid[grant_id] for one cycle, set last_winner=grant_id, increment grant_count (16-bit wrap), and go to IDLE.
REQ-016 rsp_dna, rsp_entropy, rsp_mutation and rsp_timeout SHALL hold their values until the next RESP.
REQ-017 Minimum latency SHALL be 1 cycle from req_valid to req_ready and 1 cycle from sampled done to rsp_valid.
REQ-018 proc_processing_done outside RUN SHALL be ignored.
REQ-019 A requester whose req_valid rises during another requester's job SHALL be considered at the next IDLE; no requester is starved beyond NUM_REQ-1 jobs.

Reset
REQ-020 On rst=1 at a clock edge, SHALL enter IDLE and set to 0: req_ready, rsp_valid, rsp_dna, rsp_entropy, rsp_mutation, rsp_timeout, proc_start, proc_dna_sequence, proc_aging_factor, proc_gate_select, busy, grant_id, grant_count, timeout_count.
REQ-021 After reset, last_winner SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-022 Reset mid-job SHALL abort without any rsp_valid; proc_start SHALL be 0 in the first cycle after reset.

Configuration
REQ-023 With QPA_WATCHDOG_EN defined:
- A cycle counter clears on entry to RUN.
- At TIMEOUT_CYCLES without done: clear proc_start; set rsp_dna=32'hDEADBEEF, rsp_entropy=16'hFFFF, rsp_mutation=8'hFF, rsp_timeout=1; increment timeout_count, saturating at 255; go to RESP.
- If done and the timeout occur in the same cycle, done SHALL win.
REQ-024 Without QPA_WATCHDOG_EN: RUN SHALL wait indefinitely, and rsp_timeout and timeout_count SHALL be constant 0.

Verification
REQ-025 Single job: req_valid[2]=1, dna=32'h1234ABCD, done after 5 cycles with result 32'hCAFE0001 -> req_ready[2] 1 cycle after request; proc_start high 5 cycles; rsp_valid[2] with rsp_dna=32'hCAFE0001; grant_count=1.
REQ-026 Round-robin: all four req_valid held high after reset -> grants in order 0,1,2,3,0; exactly one rsp_valid per job.
REQ-027 Withdrawal: req_valid[1] pulsed for 1 cycle only -> no req_ready, no proc_start, FSM back in IDLE, next grant still searches from requester 1.
REQ-028 Watchdog (QPA_WATCHDOG_EN, TIMEOUT_CYCLES=16), done never asserted -> rsp_valid with 32'hDEADBEEF, rsp_timeout=1, timeout_count=1; with done at cycle 16 -> normal result, rsp_timeout=0.
REQ-029 Reset in RUN: rst=1 for 1 cycle -> proc_start=0, busy=0, grant_count=0, no rsp_valid; a new request is then granted to requester 0 first.
